mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (read-only) and the load/store path of the control unit.
- Arbitrates between the two, with data priority and a fetch anti-starvation limit.
- Sequences each memory transaction: command cycle, fixed read latency, then response.
- Performs store lane steering and byte strobes, and load lane extraction with sign or zero extension (lb/lh/lw/lbu/lhu, sb/sh/sw). Misaligned accesses raise an error.

Parameters:
- RD_LATENCY, 1, cycles from memory command cycle to mem_rdata valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive fetch arbitration losses before fetch is forced to win; legal range >=1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  one-cycle pulse: fetch accepted (command or error cycle).
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched word.
- i_err  out  1  pulses with i_gnt when i_addr[1:0]!=0.
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt.
- d_we  in  1  1=store, 0=load.
- d_addr  in  32  data byte address.
- d_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
- d_unsigned  in  1  load zero-extend when 1.
- d_wdata  in  32  store data, right-justified.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only).
- d_rdata  out  32  extended load result.
- d_err  out  1  pulses with d_gnt on misaligned access.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_rd_en  out  1  read command.
- mem_wr_en  out  1  write command.
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.

Behaviour:
Reset
- All outputs 0 on rst.
- State goes to IDLE, starve_cnt=0.
- An in-flight read is dropped: no rvalid is produced for it.

States
- IDLE: requests are sampled only here. Decision is registered; the next cycle is CMD or ERR.
- CMD: drives the mem_* command and the winner's gnt for exactly one cycle. A read goes to WAIT; a write goes to IDLE.
- WAIT: counts RD_LATENCY cycles. Captures mem_rdata at the end of cycle CMD+RD_LATENCY. Next state is IDLE, with rvalid and rdata asserted in that IDLE cycle.
- ERR: one cycle; gnt and err asserted, all mem enables 0. Next state is IDLE.

Handshake and throughput
- Requester sees gnt in the CMD/ERR cycle and may drop or change its request from the following cycle.
- A new request can be sampled in the same IDLE cycle that carries rvalid.
- Read: req sampled at cycle R → gnt at R+1 → rvalid at R+2+RD_LATENCY.
- Store: gnt at R+1, next CMD at R+3 at the earliest.

Arbitration
- Only d_req: data wins.
- Only i_req: fetch wins.
- Both requesting: data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt increments on each IDLE decision where fetch requested and lost, saturating at STARVE_LIMIT. It clears when fetch is granted or i_req is low in IDLE.

Alignment
- Half access requires addr[0]==0; word access requires addr[1:0]==0; d_size=11 is always an error.
- Misaligned → ERR; memory untouched.

Stores
- mem_wdata: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- mem_wstrb: byte = 4'b0001<<addr[1:0], half = 4'b0011<<addr[1:0], word = 4'b1111.
- mem_wstrb=0 whenever mem_wr_en=0.

Loads
- Selected lane: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16].
- The lane is sign-extended, or zero-extended when d_unsigned=1.
- The lane offset uses the address latched at decision time.

Fetch
- Always a word read, mem_wstrb=0.
- i_rdata = raw mem_rdata.

Hold values
- rdata outputs hold their last value when rvalid=0.
- mem_addr holds when no command is issued.

Test Plan:
- Reset mid-read (RD_LATENCY=2): rst asserted in WAIT → no d_rvalid afterwards; all outputs 0 next cycle; a new load completes normally.
- Store byte: d_addr=0x103, d_wdata=0xA5 → CMD cycle shows mem_addr=0x100, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b1000, d_gnt=1, no d_rvalid.
- Load extension: mem_rdata=0x12F03456, d_addr=0x102:
  - lb → d_rdata=0xFFFFFFF0
  - lbu → 0x000000F0
  - lh → 0x000012F0
  - d_rvalid at R+2+RD_LATENCY
- Misaligned: lw at 0x106 → d_gnt=d_err=1 for one cycle; mem_rd_en stays 0. Same for fetch at 0x2 → i_err=1.
- Starvation (STARVE_LIMIT=4): d_req and i_req held high continuously → data granted 4 times, then fetch, then data again; starve_cnt returns to 0.
- Back-to-back: fetch read then data store queued → i_rvalid and the new arbitration decision occur in the same IDLE cycle; the store CMD follows in the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared data-memory port arbiter: instruction fetch (read-only) and the
// load/store path. Data has priority; fetch is forced through after
// STARVE_LIMIT consecutive losses. Each access is IDLE -> CMD (-> WAIT) -> IDLE,
// or IDLE -> ERR -> IDLE for a misaligned request.
module mem_port_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [1:0]      LAT_LAST   = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, ERR} state_t;

  // Transaction context latched at the decision; drives the response path.
  typedef struct packed {
    logic       fetch;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } txn_t;

  state_t        state;
  txn_t          txn;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    lat_cnt;

  logic        starved, fetch_win, data_win, i_mis, d_mis;
  logic [3:0]  st_strb;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Arbitration, alignment and store lane steering from the live request inputs
  always_comb begin
    starved   = (starve_cnt == STARVE_MAX);
    fetch_win = i_req && (!d_req || starved);
    data_win  = d_req && !fetch_win;
    i_mis     = |i_addr[1:0];
    case (d_size)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = d_addr[0];
      2'b10:   d_mis = |d_addr[1:0];
      default: d_mis = 1'b1;
    endcase
    case (d_size)
      2'b00: begin
        st_strb = 4'b0001 << d_addr[1:0];
        st_data = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << d_addr[1:0];
        st_data = {2{d_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = d_wdata;
      end
    endcase
  end

  // Load lane extraction using the offset latched at decision time
  always_comb begin
    ld_b = mem_rdata[{txn.off, 3'b000} +: 8];
    ld_h = mem_rdata[{txn.off[1], 4'b0000} +: 16];
    case (txn.size)
      2'b00:   ld_data = {{24{ld_b[7] & ~txn.uns}}, ld_b};
      2'b01:   ld_data = {{16{ld_h[15] & ~txn.uns}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // Transaction sequencer; every output is registered and pulses default low
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txn        <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      i_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
    end else begin
      i_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      i_err     <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wstrb <= '0;
      case (state)
        IDLE: begin
          if (fetch_win) begin
            starve_cnt <= '0;
            txn        <= '{fetch: 1'b1, we: 1'b0, size: 2'b10, uns: 1'b0, off: 2'b00};
            i_gnt      <= 1'b1;
            if (i_mis) begin
              i_err <= 1'b1;
              state <= ERR;
            end else begin
              mem_addr  <= {i_addr[31:2], 2'b00};
              mem_rd_en <= 1'b1;
              state     <= CMD;
            end
          end else if (data_win) begin
            // fetch cannot win while data wins, so counting only happens below the limit
            starve_cnt <= i_req ? starve_cnt + 1'b1 : '0;
            txn        <= '{fetch: 1'b0, we: d_we, size: d_size, uns: d_unsigned, off: d_addr[1:0]};
            d_gnt      <= 1'b1;
            if (d_mis) begin
              d_err <= 1'b1;
              state <= ERR;
            end else begin
              mem_addr <= {d_addr[31:2], 2'b00};
              state    <= CMD;
              if (d_we) begin
                mem_wr_en <= 1'b1;
                mem_wstrb <= st_strb;
                mem_wdata <= st_data;
              end else begin
                mem_rd_en <= 1'b1;
              end
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        CMD: begin
          lat_cnt <= '0;
          state   <= txn.we ? IDLE : WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state <= IDLE;
            if (txn.fetch) begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= ld_data;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus tasks push expected grants
// and read data; a negedge monitor pops and compares as the DUT responds.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SLIM = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.RD_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: word array, data on mem_rdata only in cycle CMD+LAT
  logic [31:0] mem [0:255];
  bit          inited = 1'b0;
  logic        rv1 = 1'b0, rv2 = 1'b0;
  logic [31:0] ra1 = '0, ra2 = '0;
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A000000 | 32'(i << 2);
      mem[64] <= 32'h12F03456;
      inited  <= 1'b1;
    end else if (mem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rv1 <= mem_rd_en; ra1 <= mem_addr;
    rv2 <= rv1;       ra2 <= ra1;
  end
  assign mem_rdata = rv2 ? mem[ra2[9:2]] : 32'hDEADBEEF;

  logic all_zero;
  assign all_zero = ~|{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                       mem_addr, mem_rd_en, mem_wr_en, mem_wstrb, mem_wdata};

  typedef struct {
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } gexp_t;

  gexp_t       dgq[$], igq[$];
  logic [31:0] drq[$], irq[$];
  bit          gq[$];          // grant log, 1 = fetch
  int          d_gnt_cyc = 0, i_gnt_cyc = 0, i_rv_cyc = 0;

  // Monitor: compare every grant and every read response against the queues
  always @(negedge clk) begin
    gexp_t e;
    if (d_gnt) begin
      gq.push_back(1'b0);
      d_gnt_cyc = cyc;
      if (dgq.size() == 0) chk(1'b0, "d_gnt_unexpected", 32'(d_gnt), 32'h0);
      else begin
        e = dgq.pop_front();
        chk(d_err == e.err, "d_err", 32'(d_err), 32'(e.err));
        if (e.err) chk(!mem_rd_en && !mem_wr_en, "d_err_mem_idle", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        else if (e.we) begin
          chk(mem_wr_en && !mem_rd_en, "st_wr_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h1);
          chk(mem_addr == e.addr, "st_addr", mem_addr, e.addr);
          chk(mem_wstrb == e.strb, "st_wstrb", 32'(mem_wstrb), 32'(e.strb));
          chk(mem_wdata == e.wdata, "st_wdata", mem_wdata, e.wdata);
        end else begin
          chk(mem_rd_en && !mem_wr_en, "ld_rd_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h2);
          chk(mem_addr == e.addr, "ld_addr", mem_addr, e.addr);
          chk(mem_wstrb == 4'h0, "ld_wstrb", 32'(mem_wstrb), 32'h0);
        end
      end
    end
    if (i_gnt) begin
      gq.push_back(1'b1);
      i_gnt_cyc = cyc;
      if (igq.size() == 0) chk(1'b0, "i_gnt_unexpected", 32'(i_gnt), 32'h0);
      else begin
        e = igq.pop_front();
        chk(i_err == e.err, "i_err", 32'(i_err), 32'(e.err));
        if (e.err) chk(!mem_rd_en && !mem_wr_en, "i_err_mem_idle", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        else begin
          chk(mem_rd_en && !mem_wr_en && mem_wstrb == 4'h0, "fe_cmd", {28'h0, mem_wstrb}, 32'h0);
          chk(mem_addr == e.addr, "fe_addr", mem_addr, e.addr);
        end
      end
    end
    if (d_rvalid) begin
      if (drq.size() == 0) chk(1'b0, "d_rvalid_unexpected", d_rdata, 32'h0);
      else begin
        logic [31:0] x;
        x = drq.pop_front();
        chk(d_rdata == x, "d_rdata", d_rdata, x);
        chk(cyc - d_gnt_cyc == LAT + 1, "d_rvalid_latency", 32'(cyc - d_gnt_cyc), 32'(LAT + 1));
      end
    end
    if (i_rvalid) begin
      i_rv_cyc = cyc;
      if (irq.size() == 0) chk(1'b0, "i_rvalid_unexpected", i_rdata, 32'h0);
      else begin
        logic [31:0] x;
        x = irq.pop_front();
        chk(i_rdata == x, "i_rdata", i_rdata, x);
        chk(cyc - i_gnt_cyc == LAT + 1, "i_rvalid_latency", 32'(cyc - i_gnt_cyc), 32'(LAT + 1));
      end
    end
  end

  task automatic drive_d(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd, input bit lat);
    int n;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_size = sz; d_unsigned = u; d_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt && n < 60);
    if (!d_gnt) chk(1'b0, "d_gnt_timeout", 32'(n), 32'h2);
    else if (lat) chk(n == 2, "d_gnt_latency", 32'(n), 32'h2);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk) chk(!d_gnt && !d_err, "d_gnt_pulse", {30'h0, d_gnt, d_err}, 32'h0);
  endtask

  task automatic drive_i(input logic [31:0] a, input bit lat);
    int n;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_gnt && n < 60);
    if (!i_gnt) chk(1'b0, "i_gnt_timeout", 32'(n), 32'h2);
    else if (lat) chk(n == 2, "i_gnt_latency", 32'(n), 32'h2);
    @(posedge clk); #1 i_req = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (LAT + 3) @(posedge clk);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] exp);
    idle_wait();
    dgq.push_back('{1'b0, 1'b0, {a[31:2], 2'b00}, 4'h0, 32'h0});
    drq.push_back(exp);
    drive_d(1'b0, a, sz, u, 32'h0, 1'b1);
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                    input logic [3:0] strb, input logic [31:0] mwd);
    idle_wait();
    dgq.push_back('{1'b0, 1'b1, {a[31:2], 2'b00}, strb, mwd});
    drive_d(1'b1, a, sz, 1'b0, wd, 1'b1);
  endtask

  task automatic bad_d(input logic we, input logic [31:0] a, input logic [1:0] sz);
    idle_wait();
    dgq.push_back('{1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    drive_d(we, a, sz, 1'b0, 32'hFFFFFFFF, 1'b1);
  endtask

  task automatic fe(input logic [31:0] a, input logic [31:0] exp);
    idle_wait();
    igq.push_back('{1'b0, 1'b0, a, 4'h0, 32'h0});
    irq.push_back(exp);
    drive_i(a, 1'b1);
  endtask

  task automatic bad_f(input logic [31:0] a);
    idle_wait();
    igq.push_back('{1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    drive_i(a, 1'b1);
  endtask

  // Both requesters held high: expect d,d,d,d,f,d
  task automatic starve_run();
    int base, n;
    logic [5:0] seq;
    idle_wait();
    for (int k = 0; k < 5; k++) dgq.push_back('{1'b0, 1'b1, 32'h204, 4'hF, 32'h11223344});
    igq.push_back('{1'b0, 1'b0, 32'h40, 4'h0, 32'h0});
    irq.push_back(32'h5A000040);
    @(posedge clk); #1;
    base = gq.size();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_size = 2'b10; d_unsigned = 1'b0;
    d_wdata = 32'h11223344; i_req = 1'b1; i_addr = 32'h40;
    n = 0;
    while (gq.size() < base + 6 && n < 300) begin @(posedge clk); n++; end
    #1 d_req = 1'b0; i_req = 1'b0;
    if (gq.size() < base + 6) chk(1'b0, "starve_timeout", 32'(gq.size() - base), 32'h6);
    else begin
      seq = '0;
      for (int k = 0; k < 6; k++) seq = {seq[4:0], gq[base + k]};
      chk(seq == 6'b000010, "starve_order", 32'(seq), 32'h02);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) chk(all_zero, "reset_outputs", 32'(all_zero), 32'h1);
    @(posedge clk); #1 rst = 1'b0;

    // load lane extraction, word at 0x100 = 0x12F03456
    ld(32'h102, 2'b00, 1'b0, 32'hFFFFFFF0);
    ld(32'h102, 2'b00, 1'b1, 32'h000000F0);
    ld(32'h102, 2'b01, 1'b0, 32'h000012F0);
    ld(32'h101, 2'b00, 1'b0, 32'h00000034);
    ld(32'h100, 2'b01, 1'b1, 32'h00003456);
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk) chk(!d_rvalid && d_rdata == 32'h00003456, "d_rdata_hold", d_rdata, 32'h00003456);

    // stores: lane replication and strobes
    st(32'h103, 2'b00, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    st(32'h202, 2'b01, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    st(32'h204, 2'b10, 32'h11223344, 4'b1111, 32'h11223344);
    st(32'h200, 2'b00, 32'h00000077, 4'b0001, 32'h77777777);
    ld(32'h102, 2'b01, 1'b0, 32'hFFFFA5F0);
    ld(32'h102, 2'b01, 1'b1, 32'h0000A5F0);
    ld(32'h100, 2'b10, 1'b0, 32'hA5F03456);
    ld(32'h200, 2'b10, 1'b0, 32'hBEEF0277);

    // fetch
    fe(32'h40, 32'h5A000040);
    fe(32'h0,  32'h5A000000);

    // misaligned: no memory command, memory untouched
    bad_d(1'b0, 32'h106, 2'b10);
    bad_d(1'b0, 32'h101, 2'b01);
    bad_d(1'b0, 32'h100, 2'b11);
    bad_d(1'b1, 32'h202, 2'b10);
    bad_f(32'h2);
    ld(32'h200, 2'b10, 1'b0, 32'hBEEF0277);

    // starvation twice: second run shows the counter cleared
    starve_run();
    starve_run();

    // back-to-back: store decided in the same IDLE cycle as the fetch rvalid
    idle_wait();
    igq.push_back('{1'b0, 1'b0, 32'h44, 4'h0, 32'h0});
    irq.push_back(32'h5A000044);
    dgq.push_back('{1'b0, 1'b1, 32'h208, 4'hF, 32'hCAFEF00D});
    fork
      drive_i(32'h44, 1'b1);
      begin
        repeat (2) @(posedge clk);
        drive_d(1'b1, 32'h208, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
      end
    join
    chk(d_gnt_cyc == i_rv_cyc + 1, "b2b_store_cmd", 32'(d_gnt_cyc - i_rv_cyc), 32'h1);
    ld(32'h208, 2'b10, 1'b0, 32'hCAFEF00D);

    // reset while a load waits: its response is dropped
    idle_wait();
    dgq.push_back('{1'b0, 1'b0, 32'h100, 4'h0, 32'h0});
    drive_d(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) chk(all_zero, "midread_reset_outputs", 32'(all_zero), 32'h1);
    repeat (6) @(posedge clk);
    ld(32'h100, 2'b10, 1'b0, 32'hA5F03456);

    repeat (LAT + 6) @(posedge clk);
    chk(dgq.size() == 0 && igq.size() == 0, "gnt_queue_drained", 32'(dgq.size() + igq.size()), 32'h0);
    chk(drq.size() == 0 && irq.size() == 0, "rdata_queue_drained", 32'(drq.size() + irq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
